// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with multi-cycle accumulate holding
module ex_mem #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_enhilo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_enhilo,
    output logic                  mem_valid,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic ex_stall;
    logic mem_stall;
    logic unused_stall_bits;

    assign ex_stall          = stall[3];
    assign mem_stall         = stall[4];
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd     <= '0;
            mem_wreg   <= 1'b0;
            mem_wdata  <= '0;
            mem_hi     <= '0;
            mem_lo     <= '0;
            mem_enhilo <= 1'b0;
            mem_valid  <= 1'b0;
            hilo_o     <= '0;
            cnt_o      <= '0;
        end else if (flush) begin
            mem_wd     <= '0;
            mem_wreg   <= 1'b0;
            mem_wdata  <= '0;
            mem_hi     <= '0;
            mem_lo     <= '0;
            mem_enhilo <= 1'b0;
            mem_valid  <= 1'b0;
            hilo_o     <= '0;
            cnt_o      <= '0;
        end else if (mem_stall) begin
            // MEM held (also covers the illegal EX-running/MEM-stalled case): keep everything
            mem_wd     <= mem_wd;
            mem_wreg   <= mem_wreg;
            mem_wdata  <= mem_wdata;
            mem_hi     <= mem_hi;
            mem_lo     <= mem_lo;
            mem_enhilo <= mem_enhilo;
            mem_valid  <= mem_valid;
            hilo_o     <= hilo_o;
            cnt_o      <= cnt_o;
        end else if (ex_stall) begin
            // EX still iterating: send a bubble downstream, carry accumulate state back
            mem_wd     <= '0;
            mem_wreg   <= 1'b0;
            mem_wdata  <= '0;
            mem_hi     <= '0;
            mem_lo     <= '0;
            mem_enhilo <= 1'b0;
            mem_valid  <= 1'b0;
            hilo_o     <= hilo_i;
            cnt_o      <= cnt_i;
        end else begin
            mem_wd     <= ex_wd;
            mem_wreg   <= ex_wreg;
            mem_wdata  <= ex_wdata;
            mem_hi     <= ex_hi;
            mem_lo     <= ex_lo;
            mem_enhilo <= ex_enhilo;
            mem_valid  <= 1'b1;
            hilo_o     <= '0;
            cnt_o      <= '0;
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - directed scoreboard bench for ex_mem
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        enhilo;
        logic        valid;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [31:0] ex_hi = '0;
    logic [31:0] ex_lo = '0;
    logic        ex_enhilo = 1'b0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_enhilo;
    logic        mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int   tests = 0;
    int   fails = 0;
    exp_t model = '0;
    exp_t sb[$];

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_enhilo(ex_enhilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_enhilo(mem_enhilo),
        .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t e;
        exp_t obs;
        obs.wd     = mem_wd;
        obs.wreg   = mem_wreg;
        obs.wdata  = mem_wdata;
        obs.hi     = mem_hi;
        obs.lo     = mem_lo;
        obs.enhilo = mem_enhilo;
        obs.valid  = mem_valid;
        obs.hilo   = hilo_o;
        obs.cnt    = cnt_o;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Predict the registered result of the coming edge, queue it, then check after the edge.
    task automatic step(input string tag);
        exp_t n;
        n = model;
        if (!rst || flush) begin
            n = '0;
        end else if (stall[4]) begin
            n = model;
        end else if (stall[3]) begin
            n      = '0;
            n.hilo = hilo_i;
            n.cnt  = cnt_i;
        end else begin
            n.wd     = ex_wd;
            n.wreg   = ex_wreg;
            n.wdata  = ex_wdata;
            n.hi     = ex_hi;
            n.lo     = ex_lo;
            n.enhilo = ex_enhilo;
            n.valid  = 1'b1;
            n.hilo   = '0;
            n.cnt    = '0;
        end
        model = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        // reset held while EX presents data
        ex_wreg  = 1'b1;
        ex_wdata = 32'hDEADBEEF;
        step("reset_hold0");
        step("reset_hold1");
        rst = 1'b1;
        step("reset_release");

        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h12345678;
        ex_hi = 32'hA; ex_lo = 32'hB; ex_enhilo = 1'b1; stall = '0;
        step("pass_through");

        stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        step("ex_stall_bubble");
        hilo_i = 64'hFFFF_0000_1234_5678; cnt_i = 2'd3;
        step("ex_stall_full_width");
        stall = '0; ex_wd = 5'd9; ex_wdata = 32'h0BADF00D; ex_enhilo = 1'b0;
        step("ex_stall_finish");

        ex_wdata = 32'h55AA55AA; ex_wd = 5'd31;
        step("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = $urandom;
            hilo_i   = {$urandom, $urandom};
            step($sformatf("full_hold%0d", i));
        end
        stall = 6'b010000; ex_wdata = 32'hCAFEBABE;
        step("illegal_mem_only_stall");
        stall = 6'b000000;
        step("resume_after_hold");

        flush = 1'b1; stall = 6'b001111; hilo_i = 64'h1; cnt_i = 2'd2;
        step("flush_over_ex_stall");
        flush = 1'b1; stall = 6'b011111;
        step("flush_over_full_stall");
        flush = 1'b0; stall = '0; ex_wdata = 32'h00C0FFEE;
        step("after_flush");

        stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'hABCD;
        step("pre_async_reset");
        #3;
        rst = 1'b0;
        #1;
        model = '0;
        sb.push_back(model);
        check("async_reset_mid_cycle");
        @(posedge clk);
        #1;
        rst = 1'b1; stall = '0; ex_wdata = 32'hFEEDFACE; ex_wd = 5'd3;
        step("fresh_after_async");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 flow CPU.
- Each clock it captures the execute-stage results: register write-back address/enable/data and the HI/LO write.
- Presents those results to the memory stage for the following cycle.
- Also holds the execute stage's multi-cycle accumulate state (64-bit partial result plus cycle counter) across EX stalls, so madd/msub-style operations complete correctly.

Parameters:
- REG_ADDR_W, 5, width of register-file write address.
- DATA_W, 32, width of data word and of HI/LO.
- CNT_W, 2, width of the multi-cycle operation counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; rst==0 forces reset state immediately.
- stall  in  6  stall vector from control; bit 3 = EX stalled, bit 4 = MEM stalled; other bits ignored.
- flush  in  1  synchronous pipeline flush (exception/eret); highest priority after reset.
- ex_wd  in  REG_ADDR_W  destination register from EX.
- ex_wreg  in  1  register write enable from EX.
- ex_wdata  in  DATA_W  result data from EX.
- ex_hi  in  DATA_W  HI value from EX.
- ex_lo  in  DATA_W  LO value from EX.
- ex_enhilo  in  1  HI/LO write enable from EX.
- hilo_i  in  2*DATA_W  EX partial 64-bit accumulate result.
- cnt_i  in  CNT_W  EX multi-cycle step counter.
- mem_wd  out  REG_ADDR_W  registered destination register to MEM.
- mem_wreg  out  1  registered write enable to MEM.
- mem_wdata  out  DATA_W  registered result to MEM.
- mem_hi  out  DATA_W  registered HI to MEM.
- mem_lo  out  DATA_W  registered LO to MEM.
- mem_enhilo  out  1  registered HI/LO enable to MEM.
- mem_valid  out  1  1 when the MEM-side slot holds a real instruction, 0 for a bubble.
- hilo_o  out  2*DATA_W  held partial result, fed back to EX.
- cnt_o  out  CNT_W  held step counter, fed back to EX.

Behaviour:
- Reset (rst==0, asynchronous assert, synchronous-to-clk release): all outputs 0; mem_wreg/mem_enhilo = 0 (unwriteable), mem_wd = 0 (NOP address), mem_valid = 0.
- Priority on each rising edge with rst==1: flush > stall decode > normal.
- flush==1:
  - MEM-side outputs take the bubble value: all zero, mem_valid = 0.
  - hilo_o and cnt_o clear to 0, regardless of stall.
- stall[3]==1 and stall[4]==0 (EX stalled, MEM proceeds):
  - Bubble inserted into MEM: all MEM-side outputs 0, mem_valid = 0.
  - hilo_o <= hilo_i and cnt_o <= cnt_i, preserving multi-cycle progress.
- stall[3]==1 and stall[4]==1: every register holds its value, including mem_valid, hilo_o and cnt_o.
- stall[3]==0 and stall[4]==0 (normal):
  - mem_wd/mem_wreg/mem_wdata/mem_hi/mem_lo/mem_enhilo <= corresponding ex_* inputs.
  - mem_valid <= 1.
  - hilo_o <= 0, cnt_o <= 0 (multi-cycle op finished or none active).
- stall[3]==0 and stall[4]==1: illegal combination from control; block must hold all registers (same as full stall), never drop or duplicate an instruction.
- Latency: exactly one cycle from ex_* to mem_* when unstalled.
- No combinational path from any input to any output.
- Widths: hilo_o/hilo_i are full 2*DATA_W with no truncation; cnt_o wraps naturally, with no saturation logic in this block.
- Reset asserted mid-stall or mid-multi-cycle op: state discarded immediately; after release the first unstalled edge loads fresh ex_* values.

Test Plan:
- Reset: hold rst=0, toggle clk with ex_wreg=1, ex_wdata=0xDEADBEEF -> all outputs 0 and mem_valid=0. Release rst -> first edge gives mem_wdata=0xDEADBEEF, mem_wreg=1, mem_valid=1.
- Pass-through: ex_wd=5'd7, ex_wreg=1, ex_wdata=0x12345678, ex_hi=0xA, ex_lo=0xB, ex_enhilo=1, stall=0 -> next edge mem_* equal these values and hilo_o=0, cnt_o=0.
- Multi-cycle: stall=6'b001111, hilo_i=64'h0000_0001_0000_0002, cnt_i=1 -> next edge: mem_wreg=0, mem_enhilo=0, mem_valid=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=1. Then stall=0 -> hilo_o=0, cnt_o=0, mem_* loaded from ex_*.
- Full hold: load mem_wdata=0x55AA55AA, then stall=6'b011111 for 3 cycles while ex_wdata changes -> mem_wdata stays 0x55AA55AA and mem_valid stays 1 throughout.
- Flush priority: flush=1 with stall=6'b001111 and hilo_i nonzero -> next edge all mem_* 0, mem_valid=0, hilo_o=0, cnt_o=0.
- Async reset mid-op: during an EX stall with cnt_o=1, drive rst=0 between clock edges -> outputs go to 0 before the next edge.
